// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer at the commit stage.
// Selects exception / interrupt / MRET for the committing instruction.
// Owns the privilege mode and holds a ready/valid PC redirect to the front end.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_RUN      | commits are evaluated; trap/MRET strobes can fire
// ST_REDIRECT | redirect held valid with flush asserted, commits ignored
module trap_ctrl #(
    parameter int MXLEN = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [MXLEN-1:0] i_pc,
    input  logic             i_exc,
    input  logic [3:0]       i_exc_code,
    input  logic [MXLEN-1:0] i_exc_tval,
    input  logic             i_mret,
    input  logic             i_mstatus_mie,
    input  logic             i_mie_meie,
    input  logic             i_mie_mtie,
    input  logic             i_mip_meip,
    input  logic             i_mip_mtip,
    input  logic [1:0]       i_mstatus_mpp,
    input  logic [MXLEN-1:0] i_mtvec,
    input  logic [MXLEN-1:0] i_mepc,
    output logic             o_trap_req,
    output logic [MXLEN-1:0] o_trap_cause,
    output logic [MXLEN-1:0] o_trap_tval,
    output logic             o_trap_mret,
    output logic [1:0]       o_priv_mode,
    output logic             o_flush,
    output logic             o_redirect_valid,
    output logic [MXLEN-1:0] o_redirect_pc,
    input  logic             i_redirect_ready
);

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_M = 2'b11;

    // Interrupt codes in mcause
    localparam logic [3:0] CODE_MEI     = 4'd11;
    localparam logic [3:0] CODE_MTI     = 4'd7;
    localparam logic [3:0] CODE_ILLEGAL = 4'd2;

    typedef enum logic {
        ST_RUN,
        ST_REDIRECT
    } state_t;

    state_t           state;
    logic             irq_en;
    logic             mei;
    logic             mti;
    logic             take_trap;
    logic             take_mret;
    logic             trap_int;
    logic [3:0]       trap_code;
    logic [MXLEN-1:0] trap_tval;
    logic [MXLEN-1:0] trap_base;
    logic [MXLEN-1:0] trap_target;
    logic [MXLEN-1:0] mret_target;
    logic [1:0]       mret_priv;

    // i_pc is recorded as mepc by the CSR file, not used here.
    logic unused_pc;
    assign unused_pc = ^i_pc;

    // Commit-event arbitration: interrupts first, then exception, then MRET.
    // Held off during reset so no strobe reaches the CSR file then.
    always_comb begin
        irq_en    = (o_priv_mode != PRIV_M) | i_mstatus_mie;
        mei       = i_mie_meie & i_mip_meip & irq_en;
        mti       = i_mie_mtie & i_mip_mtip & irq_en;
        take_trap = 1'b0;
        take_mret = 1'b0;
        trap_int  = 1'b0;
        trap_code = 4'd0;
        trap_tval = '0;
        if (state == ST_RUN && i_valid && !i_rst) begin
            if (mei) begin
                take_trap = 1'b1;
                trap_int  = 1'b1;
                trap_code = CODE_MEI;
            end else if (mti) begin
                take_trap = 1'b1;
                trap_int  = 1'b1;
                trap_code = CODE_MTI;
            end else if (i_exc) begin
                take_trap = 1'b1;
                trap_code = i_exc_code;
                trap_tval = i_exc_tval;
            end else if (i_mret && o_priv_mode != PRIV_M) begin
                // MRET from user mode is an illegal instruction
                take_trap = 1'b1;
                trap_code = CODE_ILLEGAL;
            end else if (i_mret) begin
                take_mret = 1'b1;
            end
        end
    end

    // Trap vector: vectored mode offsets interrupts by 4*code; reserved modes act as direct.
    always_comb begin
        trap_base   = {i_mtvec[MXLEN-1:2], 2'b00};
        trap_target = trap_base;
        if (i_mtvec[1:0] == 2'b01 && trap_int) begin
            trap_target = trap_base + {{(MXLEN-6){1'b0}}, trap_code, 2'b00};
        end
        mret_target = i_mepc & ~{{(MXLEN-1){1'b0}}, 1'b1};
        mret_priv   = (i_mstatus_mpp == PRIV_U) ? PRIV_U : PRIV_M;
    end

    assign o_trap_req   = take_trap;
    assign o_trap_mret  = take_mret;
    assign o_trap_cause = {trap_int, {(MXLEN-5){1'b0}}, trap_code};
    assign o_trap_tval  = trap_tval;
    assign o_flush      = take_trap | take_mret | (state == ST_REDIRECT);

    // Sequencer: latch redirect target and new privilege on an event, hold until accepted.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state            <= ST_RUN;
            o_priv_mode      <= PRIV_M;
            o_redirect_valid <= 1'b0;
            o_redirect_pc    <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (take_trap) begin
                        state            <= ST_REDIRECT;
                        o_priv_mode      <= PRIV_M;
                        o_redirect_valid <= 1'b1;
                        o_redirect_pc    <= trap_target;
                    end else if (take_mret) begin
                        state            <= ST_REDIRECT;
                        o_priv_mode      <= mret_priv;
                        o_redirect_valid <= 1'b1;
                        o_redirect_pc    <= mret_target;
                    end
                end
                ST_REDIRECT: begin
                    if (i_redirect_ready) begin
                        state            <= ST_RUN;
                        o_redirect_valid <= 1'b0;
                    end
                end
                default: begin
                    state            <= ST_RUN;
                    o_redirect_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed + randomized checks of trap_ctrl against a behavioural model.
module tb_trap_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_valid = 1'b0;
    logic [31:0] i_pc = '0;
    logic        i_exc = 1'b0;
    logic [3:0]  i_exc_code = '0;
    logic [31:0] i_exc_tval = '0;
    logic        i_mret = 1'b0;
    logic        i_mstatus_mie = 1'b0;
    logic        i_mie_meie = 1'b0;
    logic        i_mie_mtie = 1'b0;
    logic        i_mip_meip = 1'b0;
    logic        i_mip_mtip = 1'b0;
    logic [1:0]  i_mstatus_mpp = '0;
    logic [31:0] i_mtvec = '0;
    logic [31:0] i_mepc = '0;
    logic        i_redirect_ready = 1'b0;
    logic        o_trap_req;
    logic [31:0] o_trap_cause;
    logic [31:0] o_trap_tval;
    logic        o_trap_mret;
    logic [1:0]  o_priv_mode;
    logic        o_flush;
    logic        o_redirect_valid;
    logic [31:0] o_redirect_pc;

    int total = 0;
    int bad = 0;

    // model state
    logic [1:0]  m_priv;
    bit          m_redir;
    logic [31:0] m_rpc;

    trap_ctrl #(.MXLEN(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_pc(i_pc),
        .i_exc(i_exc), .i_exc_code(i_exc_code), .i_exc_tval(i_exc_tval),
        .i_mret(i_mret), .i_mstatus_mie(i_mstatus_mie), .i_mie_meie(i_mie_meie),
        .i_mie_mtie(i_mie_mtie), .i_mip_meip(i_mip_meip), .i_mip_mtip(i_mip_mtip),
        .i_mstatus_mpp(i_mstatus_mpp), .i_mtvec(i_mtvec), .i_mepc(i_mepc),
        .o_trap_req(o_trap_req), .o_trap_cause(o_trap_cause), .o_trap_tval(o_trap_tval),
        .o_trap_mret(o_trap_mret), .o_priv_mode(o_priv_mode), .o_flush(o_flush),
        .o_redirect_valid(o_redirect_valid), .o_redirect_pc(o_redirect_pc),
        .i_redirect_ready(i_redirect_ready)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called mid-cycle with inputs settled: compare against the model, then cross one edge.
    task automatic cyc();
        bit          ev_trap, ev_mret, en;
        logic [31:0] e_cause, e_tval, e_target;
        ev_trap = 0; ev_mret = 0; e_cause = 0; e_tval = 0; e_target = 0;
        if (!m_redir && i_valid) begin
            en = (m_priv != 2'd3) || i_mstatus_mie;
            if (i_mie_meie && i_mip_meip && en) begin
                ev_trap = 1; e_cause = 32'h8000_0000 + 11;
            end else if (i_mie_mtie && i_mip_mtip && en) begin
                ev_trap = 1; e_cause = 32'h8000_0000 + 7;
            end else if (i_exc) begin
                ev_trap = 1; e_cause = 32'(i_exc_code); e_tval = i_exc_tval;
            end else if (i_mret && m_priv != 2'd3) begin
                ev_trap = 1; e_cause = 2;
            end else if (i_mret) begin
                ev_mret = 1;
            end
        end
        if (ev_trap) begin
            e_target = i_mtvec & 32'hFFFF_FFFC;
            if (i_mtvec[1:0] == 2'b01 && e_cause[31])
                e_target = e_target + 4 * (e_cause & 32'hF);
        end
        chk("trap_req", 32'(o_trap_req), 32'(ev_trap));
        chk("trap_mret", 32'(o_trap_mret), 32'(ev_mret));
        chk("flush", 32'(o_flush), 32'(ev_trap || ev_mret || m_redir));
        chk("redir_valid", 32'(o_redirect_valid), 32'(m_redir));
        chk("redir_pc", o_redirect_pc, m_rpc);
        chk("priv", 32'(o_priv_mode), 32'(m_priv));
        if (ev_trap) begin
            chk("cause", o_trap_cause, e_cause);
            chk("tval", o_trap_tval, e_tval);
        end
        @(posedge i_clk);
        if (m_redir) begin
            if (i_redirect_ready) m_redir = 0;
        end else if (ev_trap) begin
            m_priv = 2'd3; m_redir = 1; m_rpc = e_target;
        end else if (ev_mret) begin
            m_priv = (i_mstatus_mpp == 2'd0) ? 2'd0 : 2'd3;
            m_redir = 1; m_rpc = i_mepc & 32'hFFFF_FFFE;
        end
        #1;
    endtask

    task automatic clear_inputs();
        i_valid = 0; i_exc = 0; i_mret = 0; i_exc_code = 0; i_exc_tval = 0;
        i_mstatus_mie = 0; i_mie_meie = 0; i_mie_mtie = 0; i_mip_meip = 0; i_mip_mtip = 0;
        i_mstatus_mpp = 0; i_redirect_ready = 1;
    endtask

    // Async reset raised mid-cycle; outputs must settle before any clock edge.
    task automatic do_reset();
        i_valid = 0; i_exc = 0; i_mret = 0;
        i_rst = 1;
        #1;
        chk("rst_priv", 32'(o_priv_mode), 32'd3);
        chk("rst_rvalid", 32'(o_redirect_valid), 32'd0);
        chk("rst_flush", 32'(o_flush), 32'd0);
        chk("rst_rpc", o_redirect_pc, 32'd0);
        m_priv = 2'd3; m_redir = 0; m_rpc = 0;
        @(posedge i_clk);
        #1;
        i_rst = 0;
    endtask

    initial begin
        m_priv = 2'd3; m_redir = 0; m_rpc = 0;
        clear_inputs();
        #12;
        do_reset();

        // synchronous exception, direct mode
        i_mtvec = 32'h8000_0000; i_pc = 32'h100;
        i_valid = 1; i_exc = 1; i_exc_code = 4'd2; i_exc_tval = 32'hDEAD;
        #1;
        chk("exc_req", 32'(o_trap_req), 32'd1);
        chk("exc_cause", o_trap_cause, 32'h2);
        chk("exc_tval", o_trap_tval, 32'hDEAD);
        cyc();
        i_valid = 0; i_exc = 0;
        #1;
        chk("exc_rvalid", 32'(o_redirect_valid), 32'd1);
        chk("exc_rpc", o_redirect_pc, 32'h8000_0000);
        cyc();
        #1; cyc();

        // vectored: MEI beats MTI, then MTI alone
        i_mtvec = 32'h8000_0001; i_mstatus_mie = 1;
        i_mie_meie = 1; i_mip_meip = 1; i_mie_mtie = 1; i_mip_mtip = 1; i_valid = 1;
        #1;
        chk("vec_mei_cause", o_trap_cause, 32'h8000_000B);
        cyc();
        #1;
        chk("vec_mei_rpc", o_redirect_pc, 32'h8000_002C);
        i_mip_meip = 0;
        cyc();
        #1;
        chk("vec_mti_cause", o_trap_cause, 32'h8000_0007);
        cyc();
        #1;
        chk("vec_mti_rpc", o_redirect_pc, 32'h8000_001C);
        i_valid = 0;
        cyc();

        // masking in M, MRET to U, then the same MTI is taken
        i_mstatus_mie = 0; i_mie_meie = 0; i_valid = 1;
        #1;
        chk("mask_no_trap", 32'(o_trap_req), 32'd0);
        cyc();
        i_mret = 1; i_mstatus_mpp = 2'd0; i_mepc = 32'h203; i_mie_mtie = 0;
        #1;
        chk("mret_strobe", 32'(o_trap_mret), 32'd1);
        cyc();
        i_mret = 0; i_valid = 0; i_mie_mtie = 1;
        #1;
        chk("mret_rpc", o_redirect_pc, 32'h202);
        chk("mret_priv", 32'(o_priv_mode), 32'd0);
        cyc();
        i_valid = 1;
        #1;
        chk("u_mti_taken", 32'(o_trap_req), 32'd1);
        cyc();
        i_valid = 0; i_mie_mtie = 0;
        #1;
        chk("u_mti_priv", 32'(o_priv_mode), 32'd3);
        cyc();

        // MRET from U is illegal
        i_valid = 1; i_mret = 1; i_mstatus_mpp = 2'd0;
        #1; cyc();
        i_valid = 0; i_mret = 0;
        #1; cyc();
        i_valid = 1; i_mret = 1;
        #1;
        chk("mret_u_cause", o_trap_cause, 32'd2);
        chk("mret_u_mret", 32'(o_trap_mret), 32'd0);
        cyc();

        // backpressure: ready low 3 cycles, commits ignored
        i_mret = 0; i_exc = 1; i_exc_code = 4'd5; i_redirect_ready = 0;
        for (int k = 0; k < 3; k++) begin
            #1; cyc();
        end
        i_redirect_ready = 1; i_valid = 0; i_exc = 0;
        #1; cyc();
        #1; chk("bp_back_run", 32'(o_redirect_valid), 32'd0);
        // async reset mid-REDIRECT
        i_valid = 1; i_exc = 1; i_redirect_ready = 0;
        #1; cyc();
        #1;
        do_reset();

        // randomized phase
        for (int n = 0; n < 600; n++) begin
            i_valid = ($urandom_range(0, 9) < 7);
            i_exc = ($urandom_range(0, 9) < 2);
            i_mret = ($urandom_range(0, 9) < 3);
            i_exc_code = 4'($urandom);
            i_exc_tval = $urandom;
            i_pc = $urandom;
            i_mstatus_mie = 1'($urandom);
            i_mie_meie = ($urandom_range(0, 3) == 0);
            i_mip_meip = 1'($urandom);
            i_mie_mtie = ($urandom_range(0, 2) == 0);
            i_mip_mtip = 1'($urandom);
            i_mstatus_mpp = 2'($urandom);
            i_mtvec = $urandom;
            i_mepc = $urandom;
            i_redirect_ready = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                #1; cyc();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
